// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector
//   Conditions a raw ring-oscillator bit stream for the TRNG APB slave.
//   A von Neumann corrector removes bias from the raw bits.
//   A repetition-count health test watches the raw stream.
//   Accepted bits are assembled into an OUT_WIDTH-bit word and handed over
//   on the go/rand_out/done interface.
//
// Ports
//   PCLK        system clock, rising edge
//   PRESETn     asynchronous active-low reset
//   go          level request; high asks for collection
//   raw_bit     raw sampled bit, already synchronous to PCLK
//   raw_valid   raw_bit is a new sample this cycle
//   rand_out    last completed random word
//   done        one-cycle pulse when rand_out has been updated
//   busy        high while collecting
//   health_fail repetition-count failure flag, held while failed
//
// state   | meaning
// IDLE    | waiting for go; entry clears word, pair phase and RCT counter
// COLLECT | pairing raw samples, assembling the word, running the RCT
// FAIL    | RCT tripped; waits for go low before returning to IDLE

module trng_entropy_collector #(
  parameter int OUT_WIDTH  = 128,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 go,
  input  logic                 raw_bit,
  input  logic                 raw_valid,
  output logic [OUT_WIDTH-1:0] rand_out,
  output logic                 done,
  output logic                 busy,
  output logic                 health_fail
);

  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FAIL} state_t;

  state_t               state, state_next;
  logic [OUT_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 phase;
  logic                 first_bit;
  logic                 prev_bit;
  logic [7:0]           rct_cnt;

  logic [7:0]           rct_next;
  logic                 rct_trip;
  logic                 accept;
  logic                 word_done;

  always_comb begin
    state_next = state;
    rct_next   = rct_cnt;
    rct_trip   = 1'b0;
    accept     = 1'b0;
    word_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) state_next = COLLECT;
      end
      COLLECT: begin
        if (raw_valid) begin
          // rct_cnt == 0 marks "no sample seen yet in this collection"
          if ((rct_cnt == 8'd0) || (raw_bit != prev_bit))
            rct_next = 8'd1;
          else if (rct_cnt != 8'(RCT_CUTOFF))
            rct_next = rct_cnt + 8'd1;
          rct_trip  = (rct_next == 8'(RCT_CUTOFF));
          accept    = phase && (raw_bit != first_bit);
          word_done = accept && (bit_cnt == CNT_W'(OUT_WIDTH - 1));
        end
        // abort beats a health trip, which beats completion
        if (!go)
          state_next = IDLE;
        else if (rct_trip)
          state_next = FAIL;
        else if (word_done)
          state_next = IDLE;
      end
      FAIL: begin
        if (!go) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      rand_out    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
      sreg        <= '0;
      bit_cnt     <= '0;
      phase       <= 1'b0;
      first_bit   <= 1'b0;
      prev_bit    <= 1'b0;
      rct_cnt     <= 8'd0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == COLLECT);
      health_fail <= (state_next == FAIL);
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            sreg    <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            rct_cnt <= 8'd0;
          end
        end
        COLLECT: begin
          if (go && !rct_trip && raw_valid) begin
            rct_cnt  <= rct_next;
            prev_bit <= raw_bit;
            phase    <= ~phase;
            if (!phase) first_bit <= raw_bit;
            if (accept) begin
              sreg    <= {sreg[OUT_WIDTH-2:0], first_bit};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (word_done) begin
              rand_out <= {sreg[OUT_WIDTH-2:0], first_bit};
              done     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
